// File: rtl/mem_request_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_request_arbiter                                                        |
// | Arbitrates instruction fetch and data load/store onto one shared RAM port. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_request_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  parameter int DATA_PRIO = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic              err,
  output logic              busy
);

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_access;
  logic w_timeout;
  logic w_done;

  // A requester whose ready pulse is out is already served; its still-high
  // level request must not be re-granted, which also hands the port to the
  // other side next (starvation avoidance).
  assign w_i_req   = i_req & ~r_i_ready;
  assign w_d_req   = (d_ren | d_wen) & ~r_d_ready;
  assign w_access  = (r_state != IDLE);
  assign w_timeout = w_access & ~ram_ready & (r_cnt == c_TMO_LAST);
  assign w_done    = w_access & (ram_ready | w_timeout);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && ((DATA_PRIO != 0) || !w_i_req)) begin
          w_grant_d = 1'b1;
          w_next    = d_wen ? DWRITE : DREAD;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
          w_next    = IFETCH;
        end
      end
      IFETCH, DREAD: begin
        ram_ren = 1'b1;
        if (w_done) w_next = IDLE;
      end
      DWRITE: begin
        ram_wen = 1'b1;
        if (w_done) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;

      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_cnt   <= '0;
      end else if (w_grant_i) begin
        r_addr <= i_addr;
        r_cnt  <= '0;
      end else if (w_access && !ram_ready) begin
        r_cnt <= r_cnt + 8'd1;
      end

      // Read data registers only move on a genuine completion, never on abort.
      if (w_done) begin
        r_err <= w_timeout;
        if (r_state == IFETCH) begin
          r_i_ready <= 1'b1;
          if (!w_timeout) r_i_rdata <= ram_rdata;
        end else begin
          r_d_ready <= 1'b1;
          if ((r_state == DREAD) && !w_timeout) r_d_rdata <= ram_rdata;
        end
      end
    end
  end

  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign err       = r_err;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = w_access;

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_request_arbiter                                                     |
// | Randomized self-checking bench against a transaction-level model.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_request_arbiter;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_PRIO    = 1;

  logic        clk = 1'b0;
  logic        nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ren;
  logic        ram_wen;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  mem_request_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (TB_TIMEOUT),
    .DATA_PRIO(TB_PRIO)
  ) u_dut (
    .clk      (clk),
    .nRST     (nRST),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .d_ren    (d_ren),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .ram_rdata(ram_rdata),
    .ram_ready(ram_ready),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Strobe cycles an access occupies: the RAM latency, capped by the timeout.
  function automatic int occ(input int lat);
    return (lat > TB_TIMEOUT) ? TB_TIMEOUT : lat;
  endfunction

  // One round: raise the chosen requests together, act as RAM with the given
  // latencies (ram_ready on access cycle lat; never if lat > TB_TIMEOUT).
  // kind: 0 fetch, 1 load, 2 store.
  task automatic run_round(input bit do_i, input bit do_d, input bit rd, input bit wr,
                           input int lat_i, input int lat_d,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] ird,
                           input logic [31:0] drd);
    int          e_kind[2];
    logic [31:0] e_addr[2];
    logic [31:0] e_rd[2];
    int          e_lat[2];
    int          e_cyc[2];
    int          n_exp = 0;
    int          got = 0;
    int          idx = -1;
    int          acc_cyc = 0;
    bit          in_acc = 0;
    bit          drop_i = 0;
    bit          drop_d = 0;
    int          dk;
    dk = wr ? 2 : 1;
    if (do_d && (TB_PRIO != 0 || !do_i)) begin
      e_kind[n_exp] = dk; e_addr[n_exp] = da; e_rd[n_exp] = drd; e_lat[n_exp] = lat_d; n_exp++;
      if (do_i) begin
        e_kind[n_exp] = 0; e_addr[n_exp] = ia; e_rd[n_exp] = ird; e_lat[n_exp] = lat_i; n_exp++;
      end
    end else begin
      if (do_i) begin
        e_kind[n_exp] = 0; e_addr[n_exp] = ia; e_rd[n_exp] = ird; e_lat[n_exp] = lat_i; n_exp++;
      end
      if (do_d) begin
        e_kind[n_exp] = dk; e_addr[n_exp] = da; e_rd[n_exp] = drd; e_lat[n_exp] = lat_d; n_exp++;
      end
    end
    e_cyc[0] = occ(e_lat[0]) + 1;

    i_req = do_i; i_addr = ia;
    d_ren = do_d & rd; d_wen = do_d & wr; d_addr = da; d_wdata = wd;

    for (int c = 1; c <= 40 && got < n_exp; c++) begin
      @(posedge clk); #1;
      if (drop_i) begin i_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_ren = 1'b0; d_wen = 1'b0; drop_d = 0; end

      if (ram_ren || ram_wen) begin
        if (!in_acc) begin
          in_acc = 1; idx++; acc_cyc = 0;
          if (idx >= n_exp) begin
            check_eq("unexpected_access", 32'd1, 32'd0);
            idx = n_exp - 1;
          end
          check_eq("ram_addr", ram_addr, e_addr[idx]);
          check_eq("strobe_type", {30'd0, ram_ren, ram_wen},
                   (e_kind[idx] == 2) ? 32'd1 : 32'd2);
          if (e_kind[idx] == 2) check_eq("ram_wdata", ram_wdata, wd);
        end
        acc_cyc++;
        ram_ready = (acc_cyc == e_lat[idx]);
        ram_rdata = ram_ready ? e_rd[idx] : $urandom;
      end else begin
        if (in_acc) check_eq("strobe_cycles", acc_cyc, occ(e_lat[idx]));
        in_acc = 0;
        ram_ready = 1'($urandom % 2);
        ram_rdata = $urandom;
      end

      if (i_ready || d_ready) begin
        check_eq("ready_which", {30'd0, i_ready, d_ready},
                 (e_kind[got] == 0) ? 32'd2 : 32'd1);
        check_eq("ready_cycle", c, e_cyc[got]);
        check_eq("err", {31'd0, err}, {31'd0, e_lat[got] > TB_TIMEOUT});
        if (e_lat[got] <= TB_TIMEOUT) begin
          if (e_kind[got] == 0) exp_i_rdata = e_rd[got];
          if (e_kind[got] == 1) exp_d_rdata = e_rd[got];
        end
        check_eq("i_rdata", i_rdata, exp_i_rdata);
        check_eq("d_rdata", d_rdata, exp_d_rdata);
        if (i_ready) drop_i = 1;
        if (d_ready) drop_d = 1;
        if (got + 1 < n_exp) e_cyc[got + 1] = c + occ(e_lat[got + 1]) + 1;
        got++;
      end
    end
    check_eq("all_completed", got, n_exp);

    // Requests drop a cycle after their pulse; nothing may be re-granted.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (drop_i) begin i_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_ren = 1'b0; d_wen = 1'b0; drop_d = 0; end
      i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
      ram_ready = 1'($urandom % 2);
      check_eq("quiet_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
      check_eq("quiet_ready", {30'd0, i_ready, d_ready}, 32'd0);
    end
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    nRST = 1'b0; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_ready = 1'b0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
    check_eq("rst_ready", {29'd0, i_ready, d_ready, err}, 32'd0);
    check_eq("rst_i_rdata", i_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_wdata", ram_wdata, 32'd0);
    nRST = 1'b1;
    @(posedge clk); #1;

    run_round(1, 0, 0, 0, 2, 1, 32'h40, 0, 0, 32'h0050_0093, 0);
    run_round(0, 1, 0, 1, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, 0);
    run_round(1, 1, 1, 0, 1, 1, 32'h44, 32'h200, 0, 32'h0000_0013, 32'h1234);
    run_round(0, 1, 1, 0, 1, 7, 0, 32'h300, 0, 0, 32'hFFFF_0000);
    run_round(0, 1, 1, 1, 1, 1, 0, 32'h400, 32'h5555_AAAA, 0, 32'h9999_9999);

    // Reset in the middle of a fetch.
    i_req = 1'b1; i_addr = 32'h80; ram_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_ren", {31'd0, ram_ren}, 32'd1);
    nRST = 1'b0; i_req = 1'b0;
    #1;
    exp_i_rdata = '0; exp_d_rdata = '0;
    check_eq("mid_rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_addr", ram_addr, 32'd0);
    check_eq("mid_rst_i_rdata", i_rdata, 32'd0);
    check_eq("mid_rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    check_eq("mid_rst_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
    nRST = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
    run_round(1, 0, 0, 0, 1, 1, 32'h84, 0, 0, 32'hCAFE_F00D, 0);

    for (int r = 0; r < 80; r++) begin
      int sel;
      int dk;
      sel = $urandom % 4;
      dk  = $urandom % 3;
      run_round(sel != 1, sel != 0, dk != 1, dk != 0,
                1 + int'($urandom % 6), 1 + int'($urandom % 6),
                $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
